div_radix2: RTL and testbench

//  Iterative 32-bit integer divider for the EX stage, the inverse of the combinational Booth/CSA multiplier path.

---
 rtl/div_radix2.sv | 168 ++++++++++++++++
 tb/tb_div_radix2.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/div_radix2.sv
// div_radix2 -- iterative restoring radix-2 integer divider for the EX stage.
//
// A start pulse accepted in IDLE latches the operand magnitudes and the result
// signs. CALC then produces one quotient bit per cycle for WIDTH cycles. FIX
// applies the sign correction and raises done for one cycle. Quotient and
// remainder stay on the outputs until a later operation completes.
//
// Optional feature: define DIV_EARLY_OUT_EN to skip CALC when |x| < |y| and
// y != 0. Results are the same in both builds; only latency differs.
//
// Ports:
//   clk            clock, all state on the rising edge
//   rstn           asynchronous active-low reset
//   EX_div_start   start request, accepted only in IDLE
//   EX_div_x       dividend, sampled on accepted start
//   EX_div_y       divisor, sampled on accepted start
//   EX_div_signed  1: two's-complement divide, 0: unsigned divide
//   EX_div_flush   abort the operation in flight; takes priority over start
//   EX_div_busy    high in CALC and FIX
//   EX_div_done    one-cycle pulse, results valid in the same cycle
//   EX_div_quo     quotient
//   EX_div_rem     remainder, sign follows the dividend
module div_radix2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             EX_div_start,
  input  logic [WIDTH-1:0] EX_div_x,
  input  logic [WIDTH-1:0] EX_div_y,
  input  logic             EX_div_signed,
  input  logic             EX_div_flush,
  output logic             EX_div_busy,
  output logic             EX_div_done,
  output logic [WIDTH-1:0] EX_div_quo,
  output logic [WIDTH-1:0] EX_div_rem
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ay;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0]   r;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] quo_q, rem_q;

  logic             sx, sy;
  logic [WIDTH-1:0] ax_in, ay_in;
  logic             accept;
  logic             early;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand magnitudes and the early-out decision, evaluated on the raw inputs
  always_comb begin
    sx     = EX_div_signed & EX_div_x[WIDTH-1];
    sy     = EX_div_signed & EX_div_y[WIDTH-1];
    ax_in  = sx ? -EX_div_x : EX_div_x;
    ay_in  = sy ? -EX_div_y : EX_div_y;
    accept = (state == S_IDLE) && EX_div_start && !EX_div_flush;
`ifdef DIV_EARLY_OUT_EN
    // A zero divisor never satisfies ax < ay, so /0 always runs full length
    early  = (ax_in < ay_in);
`else
    early  = 1'b0;
`endif
  end

  // One restoring step. The trial subtraction is two bits wider than the
  // magnitude so that its sign bit cannot be lost when |x| = 2^(WIDTH-1).
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial   = shifted - {2'b00, ay};
    ge      = ~trial[WIDTH+1];
    r_nxt   = ge ? trial[WIDTH:0] : shifted[WIDTH:0];
    q_nxt   = {q[WIDTH-2:0], ge};
  end

  always_comb begin
    quo_fix = neg_q ? -q : q;
    rem_fix = neg_r ? -r[WIDTH-1:0] : r[WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    if (EX_div_flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (EX_div_start) state_nxt = early ? S_FIX : S_CALC;
        S_CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      ay    <= '0;
      q     <= '0;
      r     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            ay    <= ay_in;
            // Divide by zero keeps the all-ones quotient unsigned-looking
            neg_q <= (sx ^ sy) & (ay_in != '0);
            neg_r <= sx;
            cnt   <= '0;
            if (early) begin
              q <= '0;
              r <= {1'b0, ax_in};
            end else begin
              q <= ax_in;
              r <= '0;
            end
          end
        end
        S_CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (!EX_div_flush) begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  // During FIX the corrected result is forwarded directly, so it is valid in
  // the same cycle as done; the registered copy holds it afterwards.
  always_comb begin
    EX_div_busy = (state != S_IDLE);
    EX_div_done = (state == S_FIX) && !EX_div_flush;
    EX_div_quo  = EX_div_done ? quo_fix : quo_q;
    EX_div_rem  = EX_div_done ? rem_fix : rem_q;
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2 -- directed self-checking bench for div_radix2.
// Table-driven vectors cover the arithmetic; hand-written sequences cover
// flush, start held high, and asynchronous reset during CALC.
module tb_div_radix2;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done;
  logic [W-1:0] quo, rem;

  int n_checks = 0;
  int n_fail   = 0;

  div_radix2 #(.WIDTH(W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .EX_div_start (start),
    .EX_div_x     (x),
    .EX_div_y     (y),
    .EX_div_signed(sgn),
    .EX_div_flush (flush),
    .EX_div_busy  (busy),
    .EX_div_done  (done),
    .EX_div_quo   (quo),
    .EX_div_rem   (rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] ma, mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    return (ma < mb) ? 1 : 33;
`else
    if (ma == mb) return 33;  // keeps both operands in use in this build
    return 33;
`endif
  endfunction

  // Issues one operation and waits (bounded) for done. lat counts falling
  // edges after the accepting rising edge up to and including the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    x = a; y = b; sgn = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; busy_cycles = 0; q = '0; r = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i; q = quo; r = rem;
        break;
      end
    end
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] gq, gr, pq, pr;
    int lat, bc, dcount;

    vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,         32'd2};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0};
    vecs[4]  = '{32'd5,        32'd0,          1'b0, 32'hFFFFFFFF,   32'd5};
    vecs[5]  = '{32'hFFFFFFF9, 32'd0,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFF9};
    vecs[6]  = '{32'hFFFFFFFF, 32'd2,          1'b0, 32'h7FFFFFFF,   32'd1};
    vecs[7]  = '{32'hFFFFFFFF, 32'd2,          1'b1, 32'd0,          32'hFFFFFFFF};
    vecs[8]  = '{32'd3,        32'd10,         1'b0, 32'd0,          32'd3};
    vecs[9]  = '{32'd10,       32'd3,          1'b0, 32'd3,          32'd1};
    vecs[10] = '{32'h80000000, 32'd7,          1'b0, 32'h12492492,   32'd2};
    vecs[11] = '{32'd0,        32'd5,          1'b0, 32'd0,          32'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quo", quo, 32'd0);
    check("rst_rem", rem, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].s, gq, gr, lat, bc);
      check($sformatf("vec%0d_quo", i), gq, vecs[i].q);
      check($sformatf("vec%0d_rem", i), gr, vecs[i].r);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].x, vecs[i].y, vecs[i].s));
      check($sformatf("vec%0d_busy_cycles", i), bc, exp_lat(vecs[i].x, vecs[i].y, vecs[i].s));
    end

    // Flush mid-CALC: no done, outputs hold, then a fresh op works
    run_op(32'd100, 32'd7, 1'b0, gq, gr, lat, bc);
    pq = quo; pr = rem;
    check("pre_flush_quo", pq, 32'd14);
    @(negedge clk);
    x = 32'd100; y = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("flush_no_done", dcount, 0);
    check("flush_quo_hold", quo, pq);
    check("flush_rem_hold", rem, pr);
    run_op(32'd9, 32'd3, 1'b0, gq, gr, lat, bc);
    check("post_flush_quo", gq, 32'd3);
    check("post_flush_rem", gr, 32'd0);

    // Start held high: accepted again only after FIX has returned to IDLE
    @(negedge clk);
    x = 32'd100; y = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int i = 1; i <= 68; i++) begin
      @(negedge clk);
      if (done) begin
        dcount++;
        check($sformatf("held_done_at_%0d", i), ((i == 33) || (i == 67)) ? 32'd1 : 32'd0, 32'd1);
        check("held_quo", quo, 32'd14);
      end
      if (i == 34) check("held_idle_gap", {31'd0, busy}, 32'd0);
      if (i == 35) check("held_restart", {31'd0, busy}, 32'd1);
    end
    check("held_done_count", dcount, 2);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("held_flush_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset during CALC clears everything at once
    @(negedge clk);
    x = 32'd100; y = 32'd7; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_quo", quo, 32'd14);
    rstn = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quo", quo, 32'd0);
    check("midrst_rem", rem, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run_op(32'd10, 32'd3, 1'b0, gq, gr, lat, bc);
    check("post_rst_quo", gq, 32'd3);
    check("post_rst_rem", gr, 32'd1);
    check("post_rst_latency", lat, exp_lat(32'd10, 32'd3, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
